// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: shadows the E/M/W
// register fields and derives forwarding selects, stalls, flushes and memory-wait bookkeeping.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             validD,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rdD,
  input  logic             regwriteD,
  input  logic             loadD,
  input  logic             memD,
  input  logic             pcsrcE,
  input  logic             dmem_ready,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0] WC_TRIP = WC_W'(TIMEOUT - 1);

  // Control state (reset)
  logic             validE_q, validE_d;
  logic             validM_q, validM_d;
  logic             validW_q, validW_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  // Register-field state (only meaningful while the matching valid is set)
  logic [REG_W-1:0] rs1E_q, rs1E_d, rs2E_q, rs2E_d, rdE_q, rdE_d;
  logic             regwriteE_q, regwriteE_d, loadE_q, loadE_d, memE_q, memE_d;
  logic [REG_W-1:0] rdM_q, rdM_d;
  logic             regwriteM_q, regwriteM_d, memM_q, memM_d;
  logic [REG_W-1:0] rdW_q, rdW_d;
  logic             regwriteW_q, regwriteW_d;

  logic       memwait, lwstall, take_branch, take_lw;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic             vE,
    input logic [REG_W-1:0] src,
    input logic             vM,
    input logic             weM,
    input logic [REG_W-1:0] dM,
    input logic             vW,
    input logic             weW,
    input logic [REG_W-1:0] dW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (vE) begin
      if (vM && weM && (dM != '0) && (dM == src))      sel = 2'b10;
      else if (vW && weW && (dW != '0) && (dW == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    memwait     = validM_q & memM_q & ~dmem_ready;
    lwstall     = validD & validE_q & loadE_q & (rdE_q != '0) &
                  ((rdE_q == rs1D) | (rdE_q == rs2D));
    take_branch = ~memwait & pcsrcE;
    take_lw     = ~memwait & ~pcsrcE & lwstall;
    fwd_a = fwd_sel(validE_q, rs1E_q, validM_q, regwriteM_q, rdM_q,
                    validW_q, regwriteW_q, rdW_q);
    fwd_b = fwd_sel(validE_q, rs2E_q, validM_q, regwriteM_q, rdM_q,
                    validW_q, regwriteW_q, rdW_q);
  end

  // Outputs are held at zero for the whole of reset, independent of the inputs.
  always_comb begin
    forwardAE    = reset_n ? fwd_a : 2'b00;
    forwardBE    = reset_n ? fwd_b : 2'b00;
    stallF       = reset_n & (memwait | take_lw);
    stallD       = reset_n & (memwait | take_lw);
    stallE       = reset_n & memwait;
    stallM       = reset_n & memwait;
    flushD       = reset_n & take_branch;
    flushE       = reset_n & (take_branch | take_lw);
    flushW       = reset_n & memwait;
    stall_cycles = stall_cycles_q;
    mem_err      = mem_err_q;
  end

  // Shadow pipeline advance
  always_comb begin
    validE_d    = validE_q;
    rs1E_d      = rs1E_q;
    rs2E_d      = rs2E_q;
    rdE_d       = rdE_q;
    regwriteE_d = regwriteE_q;
    loadE_d     = loadE_q;
    memE_d      = memE_q;
    validM_d    = validM_q;
    rdM_d       = rdM_q;
    regwriteM_d = regwriteM_q;
    memM_d      = memM_q;
    validW_d    = validW_q;
    rdW_d       = rdW_q;
    regwriteW_d = regwriteW_q;
    if (memwait) begin
      validW_d = 1'b0;
    end else begin
      validW_d    = validM_q;
      rdW_d       = rdM_q;
      regwriteW_d = regwriteM_q;
      validM_d    = validE_q;
      rdM_d       = rdE_q;
      regwriteM_d = regwriteE_q;
      memM_d      = memE_q;
      if (take_branch || take_lw) begin
        validE_d = 1'b0;
      end else begin
        validE_d    = validD;
        rs1E_d      = rs1D;
        rs2E_d      = rs2D;
        rdE_d       = rdD;
        regwriteE_d = regwriteD;
        loadE_d     = loadD;
        memE_d      = memD;
      end
    end
  end

  // Stall counter saturates; wait counter saturates at TIMEOUT so it never wraps.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((memwait || take_lw) && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    wait_cnt_d = '0;
    if (memwait)
      wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
    mem_err_d = mem_err_q | (memwait & (wait_cnt_q == WC_TRIP));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validE_q       <= 1'b0;
      validM_q       <= 1'b0;
      validW_q       <= 1'b0;
      stall_cycles_q <= '0;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      validE_q       <= validE_d;
      validM_q       <= validM_d;
      validW_q       <= validW_d;
      stall_cycles_q <= stall_cycles_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
    end
  end

  always_ff @(posedge clk) begin
    rs1E_q      <= rs1E_d;
    rs2E_q      <= rs2E_d;
    rdE_q       <= rdE_d;
    regwriteE_q <= regwriteE_d;
    loadE_q     <= loadE_d;
    memE_q      <= memE_d;
    rdM_q       <= rdM_d;
    regwriteM_q <= regwriteM_d;
    memM_q      <= memM_d;
    rdW_q       <= rdW_d;
    regwriteW_q <= regwriteW_d;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus directed bench for hazard_ctrl; a queue-based scoreboard
// compares every cycle's outputs against an instruction-level pipeline model.
module tb_hazard_ctrl;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int SC_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             validD, regwriteD, loadD, memD, pcsrcE, dmem_ready;
  logic [REG_W-1:0] rs1D, rs2D, rdD;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_err;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .rdD(rdD), .regwriteD(regwriteD), .loadD(loadD), .memD(memD),
    .pcsrcE(pcsrcE), .dmem_ready(dmem_ready), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .stall_cycles(stall_cycles), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             we, ld, mem;
  } ins_t;

  typedef struct packed {
    logic [1:0]       fa, fb;
    logic [3:0]       stalls;   // {F,D,E,M}
    logic [2:0]       flushes;  // {D,E,W}
    logic [CNT_W-1:0] sc;
    logic             me;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Instruction-level model: the three in-flight slots after D, oldest last.
  ins_t pipe[3];
  int   stall_cnt;
  int   wait_run;
  bit   err_flag;

  function automatic logic [1:0] model_fwd(input logic [REG_W-1:0] src);
    // Youngest older producer wins; x0 is never a producer.
    if (!pipe[0].v) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].v && pipe[s].we && pipe[s].rd != 0 && pipe[s].rd == src)
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic issue(input logic rstn, input logic v, input logic [REG_W-1:0] r1,
                       input logic [REG_W-1:0] r2, input logic [REG_W-1:0] rd,
                       input logic we, input logic ld, input logic mem,
                       input logic pc, input logic rdy);
    exp_t x;
    ins_t d;
    bit   mw, lw;
    @(posedge clk);
    #1;
    reset_n = rstn; validD = v; rs1D = r1; rs2D = r2; rdD = rd;
    regwriteD = we; loadD = ld; memD = mem; pcsrcE = pc; dmem_ready = rdy;
    x = '0;
    if (!rstn) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      stall_cnt = 0; wait_run = 0; err_flag = 0;
      sb.push_back(x);
    end else begin
      mw = pipe[1].v && pipe[1].mem && !rdy;
      lw = v && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
           (pipe[0].rd == r1 || pipe[0].rd == r2);
      x.fa = model_fwd(pipe[0].rs1);
      x.fb = model_fwd(pipe[0].rs2);
      x.sc = stall_cnt[CNT_W-1:0];
      x.me = err_flag;
      if (mw)      begin x.stalls = 4'b1111; x.flushes = 3'b001; end
      else if (pc) x.flushes = 3'b110;
      else if (lw) begin x.stalls = 4'b1100; x.flushes = 3'b010; end
      sb.push_back(x);
      if (x.stalls[3] && stall_cnt < SC_MAX) stall_cnt++;
      if (mw) begin
        wait_run++;
        if (wait_run >= TIMEOUT) err_flag = 1;
        pipe[2].v = 1'b0;
      end else begin
        wait_run = 0;
        d = '{v: v && !pc && !lw, rs1: r1, rs2: r2, rd: rd, we: we, ld: ld, mem: mem};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = d;
      end
    end
  endtask

  task automatic nop(input logic rdy);
    issue(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  exp_t mon;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      chk("forwardAE", int'(forwardAE), int'(mon.fa));
      chk("forwardBE", int'(forwardBE), int'(mon.fb));
      chk("stalls_FDEM", int'({stallF, stallD, stallE, stallM}), int'(mon.stalls));
      chk("flushes_DEW", int'({flushD, flushE, flushW}), int'(mon.flushes));
      chk("stall_cycles", int'(stall_cycles), int'(mon.sc));
      chk("mem_err", int'(mem_err), int'(mon.me));
    end
  end

  initial begin
    reset_n = 1'b0; validD = 0; rs1D = 0; rs2D = 0; rdD = 0;
    regwriteD = 0; loadD = 0; memD = 0; pcsrcE = 0; dmem_ready = 1;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    stall_cnt = 0; wait_run = 0; err_flag = 0;

    issue(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    // ALU RAW chain on x5
    issue(1'b1, 1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 5, 1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 5, 2, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(1'b1); nop(1'b1); nop(1'b1);
    // Load-use on x7 through rs2
    issue(1'b1, 1'b1, 1, 2, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 3, 7, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 3, 7, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(1'b1); nop(1'b1); nop(1'b1);
    // x0 writer (load) followed by x0 consumer
    issue(1'b1, 1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(1'b1); nop(1'b1); nop(1'b1);
    // Branch coinciding with a load-use
    issue(1'b1, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 3, 1, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    nop(1'b1); nop(1'b1); nop(1'b1);
    // Three-cycle memory wait, then a four-cycle wait that trips mem_err
    issue(1'b1, 1'b1, 1, 2, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    nop(1'b1);
    nop(1'b0); nop(1'b0); nop(1'b0); nop(1'b1);
    issue(1'b1, 1'b1, 1, 2, 11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nop(1'b1);
    nop(1'b0); nop(1'b0); nop(1'b0); nop(1'b0); nop(1'b1); nop(1'b1);
    // Reset asserted in the middle of a wait
    issue(1'b1, 1'b1, 1, 2, 12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    nop(1'b1);
    nop(1'b0); nop(1'b0);
    issue(1'b0, 1'b1, 12, 12, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 12, 12, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(1'b0); nop(1'b1);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic ld_r;
      ld_r = ($urandom_range(0, 2) == 0);
      issue(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 4) != 0),
            REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 3)),
            ld_r | ($urandom_range(0, 1) == 1), ld_r,
            ld_r | ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 1) == 1));
    end
    issue(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
